rv_fetch: RTL and testbench

Instruction-fetch front end for the RV core: the initiator side of the `rv_memory` instruction port. It owns the PC register, drives `pc_Q100H`/`ready_Q101H` into instruction memory and consumes `instruction_Q101H`. It presents a PC/instruction/valid triple to decode in Q101H. It handles decode back-pressure with a hold register, and handles taken-branch redirects from Q102H with wrong-path squash.

---
 rtl/rv_pkg.sv | 22 ++
 rtl/rv_fetch_if.sv | 41 ++++
 rtl/rv_fetch.sv | 103 ++++++++++
 tb/tb_rv_fetch.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared types and constants for the RV core front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int XLEN = 32;

    // Canonical NOP: addi x0, x0, 0
    localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        REDIR = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/rv_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : rv_fetch_if
//  Description : Fetch-unit bundle: instruction-memory request/response,
//                decode hand-off and execute redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rv_fetch_if;
    import rv_pkg::*;

    // Instruction memory side
    logic [XLEN-1:0] pc_Q100H;
    logic            ready_Q101H;
    logic [XLEN-1:0] instruction_Q101H;

    // Decode side
    logic            stall_Q101H;
    logic            valid_Q101H;
    logic [XLEN-1:0] instr_Q101H;
    logic [XLEN-1:0] pc_Q101H;

    // Execute redirect
    logic            branch_taken_Q102H;
    logic [XLEN-1:0] branch_target_Q102H;

    // Fetch unit
    modport master (
        output pc_Q100H, ready_Q101H, valid_Q101H, instr_Q101H, pc_Q101H,
        input  instruction_Q101H, stall_Q101H,
               branch_taken_Q102H, branch_target_Q102H
    );

    // Memory / decode / execute environment
    modport slave (
        input  pc_Q100H, ready_Q101H, valid_Q101H, instr_Q101H, pc_Q101H,
        output instruction_Q101H, stall_Q101H,
               branch_taken_Q102H, branch_target_Q102H
    );

endinterface
`default_nettype wire

// File: rtl/rv_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : rv_fetch
//  Description : Instruction-fetch front end. Owns the PC, issues requests to
//                instruction memory, presents PC/instruction/valid to decode,
//                absorbs decode stalls with a hold register and squashes the
//                wrong path on taken-branch redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_fetch
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic  clk,
    input  wire logic  rst,
    rv_fetch_if.master bus
);

    localparam logic [XLEN-1:0] c_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] c_PC_STEP    = 32'd4;

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc_q100h;
    logic [XLEN-1:0] r_pc_q101h;
    logic [XLEN-1:0] r_hold;

    logic            w_valid;
    logic            w_ready;
    logic            w_redirect;
    logic            w_stall_hit;
    logic [XLEN-1:0] w_target;

    assign w_redirect = bus.branch_taken_Q102H;
    // Low two target bits are dropped: fetch is word-aligned only.
    assign w_target   = bus.branch_target_Q102H & c_ALIGN_MASK;

    // Decode-facing valid/ready and the next-state decision.
    always_comb begin
        w_valid      = 1'b0;
        w_stall_hit  = 1'b0;
        w_ready      = 1'b0;
        w_state_next = r_state;

        // A redirect squashes whatever is in Q101H this very cycle.
        w_valid     = ((r_state == RUN) || (r_state == HOLD)) && !w_redirect;
        w_stall_hit = bus.stall_Q101H && w_valid;
        // Combinational stall->ready path: memory must not advance while
        // decode refuses a live instruction, unless a redirect overrides it.
        w_ready     = !rst && !w_stall_hit;

        if (w_redirect) begin
            w_state_next = REDIR;
        end else begin
            case (r_state)
                BOOT:    w_state_next = RUN;
                RUN:     w_state_next = w_stall_hit ? HOLD : RUN;
                HOLD:    w_state_next = bus.stall_Q101H ? HOLD : RUN;
                REDIR:   w_state_next = w_stall_hit ? HOLD : RUN;
                default: w_state_next = BOOT;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= BOOT;
        else     r_state <= w_state_next;
    end

    // Fetch PC: redirect beats advance; frozen while memory is not requested.
    always_ff @(posedge clk) begin
        if (rst)             r_pc_q100h <= RESET_PC;
        else if (w_redirect) r_pc_q100h <= w_target;
        else if (w_ready)    r_pc_q100h <= r_pc_q100h + c_PC_STEP;
    end

    // Q101H PC follows every request memory actually captured.
    always_ff @(posedge clk) begin
        if (rst)          r_pc_q101h <= '0;
        else if (w_ready) r_pc_q101h <= r_pc_q100h;
    end

    // Hold register: snapshot memory data on the first stalled edge so the
    // instruction survives while memory output is no longer guaranteed.
    always_ff @(posedge clk) begin
        if (rst)             r_hold <= RV_NOP;
        else if (w_redirect) r_hold <= RV_NOP;
        else if (((r_state == RUN) || (r_state == REDIR)) && w_stall_hit)
            r_hold <= bus.instruction_Q101H;
    end

    assign bus.pc_Q100H    = r_pc_q100h;
    assign bus.ready_Q101H = w_ready;
    assign bus.valid_Q101H = w_valid;
    assign bus.pc_Q101H    = r_pc_q101h;
    // BOOT also shows the hold register so decode sees a NOP out of reset.
    assign bus.instr_Q101H = ((r_state == HOLD) || (r_state == BOOT)) ?
                             r_hold : bus.instruction_Q101H;

endmodule
`default_nettype wire

// File: tb/tb_rv_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_fetch
//  Description : Directed self-checking bench for rv_fetch with a behavioural
//                instruction memory where mem[i] = 32'h1000_0000 + i.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_fetch;
    import rv_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic [31:0] mem [0:63];

    rv_fetch_if bus ();
    rv_fetch_if bus_w ();

    rv_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    rv_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus_w.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memories: capture the request on the edge when ready is high.
    always_ff @(posedge clk) begin
        if (bus.ready_Q101H) bus.instruction_Q101H <= mem[bus.pc_Q100H[7:2]];
    end

    always_ff @(posedge clk) begin
        if (bus_w.ready_Q101H) bus_w.instruction_Q101H <= mem[bus_w.pc_Q100H[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle and leave 1 time unit for input updates.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;

        rst = 1'b1;
        bus.stall_Q101H = 1'b0;
        bus.branch_taken_Q102H = 1'b0;
        bus.branch_target_Q102H = 32'h0;
        bus_w.stall_Q101H = 1'b0;
        bus_w.branch_taken_Q102H = 1'b0;
        bus_w.branch_target_Q102H = 32'h0;

        repeat (3) next_cycle();
        #1;
        // Reset values while rst is still high
        chk("rst_pc100",  bus.pc_Q100H, 32'h0);
        chk("rst_ready",  32'(bus.ready_Q101H), 32'h0);
        chk("rst_valid",  32'(bus.valid_Q101H), 32'h0);
        chk("rst_instr",  bus.instr_Q101H, 32'h0000_0013);
        chk("rst_pc101",  bus.pc_Q101H, 32'h0);
        chk("rst_wpc100", bus_w.pc_Q100H, 32'hFFFF_FFF8);

        // BOOT
        next_cycle();
        rst = 1'b0;
        #1;
        chk("boot_valid", 32'(bus.valid_Q101H), 32'h0);
        chk("boot_ready", 32'(bus.ready_Q101H), 32'h1);
        chk("boot_pc100", bus.pc_Q100H, 32'h0);
        chk("boot_wvalid", 32'(bus_w.valid_Q101H), 32'h0);

        // First instruction
        next_cycle(); #1;
        chk("i0_valid", 32'(bus.valid_Q101H), 32'h1);
        chk("i0_instr", bus.instr_Q101H, 32'h1000_0000);
        chk("i0_pc101", bus.pc_Q101H, 32'h0);
        chk("i0_pc100", bus.pc_Q100H, 32'h4);
        chk("w0_pc101", bus_w.pc_Q101H, 32'hFFFF_FFF8);
        chk("w0_instr", bus_w.instr_Q101H, 32'h1000_003E);

        next_cycle(); #1;
        chk("i1_instr", bus.instr_Q101H, 32'h1000_0001);
        chk("i1_pc101", bus.pc_Q101H, 32'h4);
        chk("w1_pc101", bus_w.pc_Q101H, 32'hFFFF_FFFC);
        chk("w1_instr", bus_w.instr_Q101H, 32'h1000_003F);

        // Stall for three cycles on instruction 2
        next_cycle();
        bus.stall_Q101H = 1'b1;
        #1;
        chk("w2_pc101", bus_w.pc_Q101H, 32'h0000_0000);
        chk("w2_instr", bus_w.instr_Q101H, 32'h1000_0000);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin next_cycle(); #1; end
            chk("st_valid", 32'(bus.valid_Q101H), 32'h1);
            chk("st_instr", bus.instr_Q101H, 32'h1000_0002);
            chk("st_pc101", bus.pc_Q101H, 32'h8);
            chk("st_ready", 32'(bus.ready_Q101H), 32'h0);
            chk("st_pc100", bus.pc_Q100H, 32'hC);
        end

        // Stall drops: held instruction still presented, ready returns
        next_cycle();
        bus.stall_Q101H = 1'b0;
        #1;
        chk("rel_instr", bus.instr_Q101H, 32'h1000_0002);
        chk("rel_valid", 32'(bus.valid_Q101H), 32'h1);
        chk("rel_ready", 32'(bus.ready_Q101H), 32'h1);

        next_cycle(); #1;
        chk("i3_instr", bus.instr_Q101H, 32'h1000_0003);
        chk("i3_pc101", bus.pc_Q101H, 32'hC);

        next_cycle(); #1;
        chk("i4_instr", bus.instr_Q101H, 32'h1000_0004);

        // Redirect to 0x40 at cycle N
        next_cycle();
        bus.branch_taken_Q102H = 1'b1;
        bus.branch_target_Q102H = 32'h40;
        #1;
        chk("br_n_valid", 32'(bus.valid_Q101H), 32'h0);
        chk("br_n_ready", 32'(bus.ready_Q101H), 32'h1);

        next_cycle();
        bus.branch_taken_Q102H = 1'b0;
        #1;
        chk("br_n1_valid", 32'(bus.valid_Q101H), 32'h0);
        chk("br_n1_pc100", bus.pc_Q100H, 32'h40);
        chk("br_n1_ready", 32'(bus.ready_Q101H), 32'h1);

        next_cycle(); #1;
        chk("br_n2_valid", 32'(bus.valid_Q101H), 32'h1);
        chk("br_n2_instr", bus.instr_Q101H, 32'h1000_0010);
        chk("br_n2_pc101", bus.pc_Q101H, 32'h40);

        // Redirect while stalled: stall on 0x11, then branch to 0x22
        next_cycle();
        bus.stall_Q101H = 1'b1;
        #1;
        chk("bs_instr", bus.instr_Q101H, 32'h1000_0011);
        chk("bs_ready", 32'(bus.ready_Q101H), 32'h0);

        next_cycle(); #1;
        chk("bs_hold", bus.instr_Q101H, 32'h1000_0011);

        next_cycle();
        bus.branch_taken_Q102H = 1'b1;
        bus.branch_target_Q102H = 32'h22;
        #1;
        chk("bs_br_valid", 32'(bus.valid_Q101H), 32'h0);
        chk("bs_br_ready", 32'(bus.ready_Q101H), 32'h1);

        next_cycle();
        bus.branch_taken_Q102H = 1'b0;
        bus.stall_Q101H = 1'b0;
        #1;
        chk("bs_redir_pc100", bus.pc_Q100H, 32'h20);
        chk("bs_redir_valid", 32'(bus.valid_Q101H), 32'h0);

        next_cycle(); #1;
        chk("bs_tgt_valid", 32'(bus.valid_Q101H), 32'h1);
        chk("bs_tgt_instr", bus.instr_Q101H, 32'h1000_0008);
        chk("bs_tgt_pc101", bus.pc_Q101H, 32'h20);

        // Mid-run reset for one cycle
        next_cycle();
        rst = 1'b1;
        #1;
        chk("mr_ready", 32'(bus.ready_Q101H), 32'h0);

        next_cycle();
        rst = 1'b0;
        #1;
        chk("mr_valid", 32'(bus.valid_Q101H), 32'h0);
        chk("mr_pc100", bus.pc_Q100H, 32'h0);
        chk("mr_pc101", bus.pc_Q101H, 32'h0);
        chk("mr_instr", bus.instr_Q101H, 32'h0000_0013);

        next_cycle(); #1;
        chk("mr_i0_valid", 32'(bus.valid_Q101H), 32'h1);
        chk("mr_i0_instr", bus.instr_Q101H, 32'h1000_0000);
        chk("mr_i0_pc101", bus.pc_Q101H, 32'h0);

        next_cycle(); #1;
        chk("mr_i1_instr", bus.instr_Q101H, 32'h1000_0001);
        chk("mr_i1_pc101", bus.pc_Q101H, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
